// File: rtl/rx_pkg.sv
// Shared constants for the USB receive bit-recovery slice.
// Holds parameter defaults, the byte bit-counter width and a counter width helper.
package rx_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 8;
  localparam int unsigned SAMPLE_PHASE_DEF = 3;
  localparam int unsigned STUFF_LIMIT_DEF  = 6;
  localparam int unsigned BIT_CNT_W        = 3;

  // Bits needed to hold values 0..n-1 (minimum 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_bit_recover_if.sv
// Line-side inputs and recovered-bit strobes of rx_bit_recover.
//   master: drives d_plus, d_edge, rcving; observes the strobes
//   slave : the recovery block
interface rx_bit_recover_if;

  logic d_plus;
  logic d_edge;
  logic rcving;
  logic shift_enable;
  logic d_orig;
  logic byte_done;
  logic stuff_err;

  modport master (
    output d_plus, d_edge, rcving,
    input  shift_enable, d_orig, byte_done, stuff_err
  );

  modport slave (
    input  d_plus, d_edge, rcving,
    output shift_enable, d_orig, byte_done, stuff_err
  );

endinterface

// File: rtl/rx_bit_timer.sv
// Bit-period timer: counts clocks within a USB bit, resyncs on line edges and
// flags the sample point.
//   clk, rst     : clock, async active-high reset
//   rcving_i     : packet in progress; low holds the count at 0
//   d_edge_i     : line transition pulse, restarts the period
//   count_o      : current position in the bit period
//   sample_c_o   : combinational sample strobe for this cycle
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned SAMPLE_PHASE = SAMPLE_PHASE_DEF,
  localparam int unsigned CW = cnt_w(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rcving_i,
  input  logic          d_edge_i,
  output logic [CW-1:0] count_o,
  output logic          sample_c_o
);

  logic [CW-1:0] count_q, count_d;

  // The edge cycle itself is position 0, so the next cycle is position 1.
  always_comb begin
    count_d = count_q + CW'(1);
    if (!rcving_i) begin
      count_d = '0;
    end else if (d_edge_i) begin
      count_d = CW'(1);
    end else if (count_q == CW'(CLKS_PER_BIT - 1)) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // An edge landing on the sample phase wins: resync, no sample.
  assign sample_c_o = rcving_i && !d_edge_i && (count_q == CW'(SAMPLE_PHASE));
  assign count_o    = count_q;

endmodule

// File: rtl/rx_bit_recover.sv
// USB receive bit recovery: NRZI decode, bit unstuffing and byte framing.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of rx_bit_recover_if (line inputs, registered strobes)
module rx_bit_recover
  import rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned SAMPLE_PHASE = SAMPLE_PHASE_DEF,
  parameter int unsigned STUFF_LIMIT  = STUFF_LIMIT_DEF
) (
  input logic              clk,
  input logic              rst,
  rx_bit_recover_if.slave  bus
);

  localparam int unsigned CW = cnt_w(CLKS_PER_BIT);
  localparam int unsigned OW = cnt_w(STUFF_LIMIT + 1);

  logic [CW-1:0]        count;
  logic                 sample_c;
  logic                 dec_c;

  logic                 prev_level_q, prev_level_d;
  logic [OW-1:0]        ones_cnt_q, ones_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 shift_enable_q, shift_enable_d;
  logic                 d_orig_q, d_orig_d;
  logic                 byte_done_q, byte_done_d;
  logic                 stuff_err_q, stuff_err_d;

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_PHASE (SAMPLE_PHASE)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .rcving_i   (bus.rcving),
    .d_edge_i   (bus.d_edge),
    .count_o    (count),
    .sample_c_o (sample_c)
  );

  // NRZI: no level change means a 1.
  assign dec_c = (bus.d_plus == prev_level_q);

  // Decode, unstuff and frame; strobes default low so they last one cycle.
  always_comb begin
    prev_level_d   = prev_level_q;
    ones_cnt_d     = ones_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    d_orig_d       = d_orig_q;
    shift_enable_d = 1'b0;
    byte_done_d    = 1'b0;
    stuff_err_d    = 1'b0;
    if (!bus.rcving) begin
      prev_level_d = 1'b1;
      ones_cnt_d   = '0;
      bit_cnt_d    = '0;
    end else if (sample_c) begin
      prev_level_d = bus.d_plus;
      if (ones_cnt_q == OW'(STUFF_LIMIT)) begin
        // Stuffed bit: drop it; a 1 here means the transmitter broke the rule.
        ones_cnt_d  = '0;
        stuff_err_d = dec_c;
      end else begin
        shift_enable_d = 1'b1;
        d_orig_d       = dec_c;
        ones_cnt_d     = dec_c ? (ones_cnt_q + OW'(1)) : '0;
        bit_cnt_d      = bit_cnt_q + BIT_CNT_W'(1);
        byte_done_d    = (bit_cnt_q == {BIT_CNT_W{1'b1}});
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_level_q   <= 1'b1;
      ones_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_enable_q <= 1'b0;
      d_orig_q       <= 1'b1;
      byte_done_q    <= 1'b0;
      stuff_err_q    <= 1'b0;
    end else begin
      prev_level_q   <= prev_level_d;
      ones_cnt_q     <= ones_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_enable_q <= shift_enable_d;
      d_orig_q       <= d_orig_d;
      byte_done_q    <= byte_done_d;
      stuff_err_q    <= stuff_err_d;
    end
  end

  assign bus.shift_enable = shift_enable_q;
  assign bus.d_orig       = d_orig_q;
  assign bus.byte_done    = byte_done_q;
  assign bus.stuff_err    = stuff_err_q;

endmodule

// File: tb/tb_rx_bit_recover.sv
// Directed bench for rx_bit_recover: per-bit-period vector table plus
// hand-written sequences for resync, reset and rcving-drop corners.
module tb_rx_bit_recover;

  localparam int CPB = 8;

  typedef struct {
    logic restart;  // drop rcving briefly before this bit
    logic lvl;      // d_plus for the whole bit period
    logic edg;      // d_edge pulse on the first clock of the period
    logic strb;     // expected one strobe in the period
    logic dorig;    // expected d_orig at that strobe
    logic bd;       // expected byte_done in the period
    logic se;       // expected stuff_err in the period
  } vec_t;

  logic clk;
  logic rst;
  rx_bit_recover_if bus ();

  rx_bit_recover dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests;
  int   n_fail;
  int   pw_viol;
  logic model_dorig;
  logic prev_sh, prev_bd, prev_se;
  vec_t vecs[$];

  // Strobes must never stay high for two consecutive cycles.
  initial begin
    pw_viol = 0;
    prev_sh = 1'b0;
    prev_bd = 1'b0;
    prev_se = 1'b0;
  end
  always @(negedge clk) begin
    if (bus.shift_enable && prev_sh) pw_viol++;
    if (bus.byte_done && prev_bd) pw_viol++;
    if (bus.stuff_err && prev_se) pw_viol++;
    prev_sh = bus.shift_enable;
    prev_bd = bus.byte_done;
    prev_se = bus.stuff_err;
  end

  function automatic vec_t mk(input logic restart, input logic lvl, input logic edg,
                              input logic strb, input logic dorig, input logic bd,
                              input logic se);
    vec_t v;
    v.restart = restart;
    v.lvl     = lvl;
    v.edg     = edg;
    v.strb    = strb;
    v.dorig   = dorig;
    v.bd      = bd;
    v.se      = se;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Idle the line with rcving low, then start a packet aligned to count 0.
  task automatic restart;
    bus.rcving = 1'b0;
    bus.d_plus = 1'b1;
    bus.d_edge = 1'b0;
    tick();
    tick();
    bus.rcving = 1'b1;
  endtask

  // Drive one bit period and check its strobes.
  task automatic run_bit(input vec_t v, input string tag);
    int   strobes;
    int   offs;
    logic got_d;
    logic bd;
    logic se;
    strobes = 0;
    offs    = -1;
    got_d   = 1'b0;
    bd      = 1'b0;
    se      = 1'b0;
    for (int c = 0; c < CPB; c++) begin
      bus.d_plus = v.lvl;
      bus.d_edge = (c == 0) ? v.edg : 1'b0;
      tick();
      if (bus.shift_enable) begin
        strobes++;
        offs  = c;
        got_d = bus.d_orig;
      end
      bd = bd | bus.byte_done;
      se = se | bus.stuff_err;
    end
    bus.d_edge = 1'b0;
    chk({tag, " strobes"}, strobes, v.strb ? 1 : 0);
    if (v.strb) begin
      model_dorig = v.dorig;
      chk({tag, " strobe phase"}, offs, 3);
      chk({tag, " d_orig"}, int'(got_d), int'(v.dorig));
    end
    chk({tag, " byte_done"}, int'(bd), int'(v.bd));
    chk({tag, " stuff_err"}, int'(se), int'(v.se));
    chk({tag, " d_orig hold"}, int'(bus.d_orig), int'(model_dorig));
  endtask

  initial begin
    int first;
    n_tests     = 0;
    n_fail      = 0;
    model_dorig = 1'b1;

    // Steady 1s: six delivered, 7th dropped with stuff_err, byte_done on 8th delivered.
    for (int i = 0; i < 6; i++) vecs.push_back(mk(i == 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0));
    // Toggle every bit: eight 0s, byte_done on the 8th only.
    for (int i = 0; i < 8; i++) vecs.push_back(mk(i == 0, logic'(i % 2), 1, 1, 0, logic'(i == 7), 0));
    // Six 1s, stuffed 0 dropped silently, then 0 and 1.
    for (int i = 0; i < 6; i++) vecs.push_back(mk(i == 0, 1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0));

    // Reset state
    rst        = 1'b1;
    bus.rcving = 1'b0;
    bus.d_plus = 1'b1;
    bus.d_edge = 1'b0;
    tick();
    tick();
    chk("rst shift_enable", int'(bus.shift_enable), 0);
    chk("rst d_orig", int'(bus.d_orig), 1);
    chk("rst byte_done", int'(bus.byte_done), 0);
    chk("rst stuff_err", int'(bus.stuff_err), 0);
    chk("rst count", int'(dut.u_timer.count_q), 0);
    chk("rst prev_level", int'(dut.prev_level_q), 1);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].restart) restart();
      run_bit(vecs[i], $sformatf("vec%0d", i));
    end

    // Edge at count=5 resyncs to 1; strobe 3 clocks later.
    restart();
    run_bit(mk(0, 1, 0, 1, 1, 0, 0), "pre-resync");
    for (int c = 0; c < 5; c++) tick();
    chk("resync5 count before", int'(dut.u_timer.count_q), 5);
    bus.d_edge = 1'b1;
    tick();
    bus.d_edge = 1'b0;
    chk("resync5 count after", int'(dut.u_timer.count_q), 1);
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (bus.shift_enable && first == 0) first = i;
    end
    chk("resync5 strobe delay", first, 3);

    // Edge on the sample phase: no sample, resync.
    restart();
    for (int c = 0; c < 3; c++) tick();
    chk("resync3 count before", int'(dut.u_timer.count_q), 3);
    bus.d_edge = 1'b1;
    tick();
    bus.d_edge = 1'b0;
    chk("resync3 no strobe", int'(bus.shift_enable), 0);
    chk("resync3 count after", int'(dut.u_timer.count_q), 1);
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (bus.shift_enable && first == 0) first = i;
    end
    chk("resync3 strobe delay", first, 3);

    // Reset in bit 5 of a byte, then a fresh byte.
    restart();
    for (int i = 0; i < 4; i++) run_bit(mk(0, logic'(i % 2), 1, 1, 0, 0, 0), $sformatf("prerst%0d", i));
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midrst shift_enable", int'(bus.shift_enable), 0);
    chk("midrst d_orig", int'(bus.d_orig), 1);
    chk("midrst byte_done", int'(bus.byte_done), 0);
    chk("midrst stuff_err", int'(bus.stuff_err), 0);
    chk("midrst bit_cnt", int'(dut.bit_cnt_q), 0);
    chk("midrst count", int'(dut.u_timer.count_q), 0);
    model_dorig = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_bit(mk(0, logic'(i % 2), 1, 1, 0, logic'(i == 7), 0), $sformatf("postrst%0d", i));

    // rcving dropped in the sample cycle.
    restart();
    run_bit(mk(0, 1, 0, 1, 1, 0, 0), "predrop");
    for (int c = 0; c < 3; c++) tick();
    chk("drop count before", int'(dut.u_timer.count_q), 3);
    bus.rcving = 1'b0;
    tick();
    chk("drop no strobe", int'(bus.shift_enable), 0);
    chk("drop count", int'(dut.u_timer.count_q), 0);
    chk("drop ones_cnt", int'(dut.ones_cnt_q), 0);
    chk("drop bit_cnt", int'(dut.bit_cnt_q), 0);
    tick();
    chk("drop still quiet", int'(bus.shift_enable), 0);

    chk("pulse width", pw_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
